bulls_cows_solver: RTL and testbench

Automatic code-breaker for the Bulls & Cows game: the opposite end of the guess/score protocol from the game scorer. It emits 4-digit BCD guesses with a one-cycle `confirm` pulse, takes back the bulls/cows score, and keeps a history of scored guesses. Each next guess is the lowest code consistent with every recorded score. Used for self-play and as an automated opponent on the scorer's guess input.

---
 rtl/bulls_cows_solver.sv | 216 +++++++++++++++++++++
 tb/tb_bulls_cows_solver.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bulls_cows_solver.sv
// Bulls & Cows code-breaker: issues the lowest 4-digit BCD code consistent with
// every scored guess so far, one candidate skip or history compare per cycle.
module bulls_cows_solver #(
    parameter int unsigned MAX_GUESSES = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        score_valid,
    input  logic [3:0]  bulls,
    input  logic [3:0]  cows,
    output logic [15:0] guess,
    output logic        confirm,
    output logic        busy,
    output logic        solved,
    output logic        fail,
    output logic [3:0]  guess_count
);

    localparam int unsigned CODE_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DIG_W  = 4;
    localparam logic [CODE_W-1:0] FIRST_CODE = 16'h0123;
    localparam logic [CODE_W-1:0] LAST_CODE  = 16'h9876;

    typedef enum logic [2:0] {
        S_IDLE, S_SEARCH, S_ISSUE, S_WAIT, S_DONE, S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [CODE_W-1:0]  cand_q, cand_d;
    logic [CODE_W-1:0]  guess_q, guess_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   hist_count_q, hist_count_d;
    logic               confirm_q, confirm_d;
    logic               busy_q, busy_d;
    logic               solved_q, solved_d;
    logic               fail_q, fail_d;

    logic [CODE_W-1:0]  hist_guess_q [MAX_GUESSES];
    logic [CODE_W-1:0]  hist_guess_d [MAX_GUESSES];
    logic [CNT_W-1:0]   hist_bulls_q [MAX_GUESSES];
    logic [CNT_W-1:0]   hist_bulls_d [MAX_GUESSES];
    logic [CNT_W-1:0]   hist_cows_q  [MAX_GUESSES];
    logic [CNT_W-1:0]   hist_cows_d  [MAX_GUESSES];

    logic [CODE_W-1:0]  sel_guess;
    logic [CNT_W-1:0]   sel_bulls, sel_cows;
    logic [CNT_W-1:0]   cand_bulls, cand_cows;
    logic               cand_ok, cand_match, inc_req;

    function automatic logic [CODE_W-1:0] bcd_inc(input logic [CODE_W-1:0] v);
        logic [CODE_W-1:0] r;
        logic              carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[DIG_W*i +: DIG_W] == 4'd9) begin
                    r[DIG_W*i +: DIG_W] = 4'd0;
                end else begin
                    r[DIG_W*i +: DIG_W] = v[DIG_W*i +: DIG_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // History entry addressed by idx
    always_comb begin
        sel_guess = '0;
        sel_bulls = '0;
        sel_cows  = '0;
        for (int unsigned i = 0; i < MAX_GUESSES; i++) begin
            if (CNT_W'(i) == idx_q) begin
                sel_guess = hist_guess_q[i];
                sel_bulls = hist_bulls_q[i];
                sel_cows  = hist_cows_q[i];
            end
        end
    end

    // Candidate legality and its score against the selected history entry
    always_comb begin
        cand_ok    = 1'b1;
        cand_bulls = '0;
        cand_cows  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (cand_q[DIG_W*i +: DIG_W] > 4'd9) cand_ok = 1'b0;
            for (int unsigned j = 0; j < 4; j++) begin
                if (j > i && cand_q[DIG_W*i +: DIG_W] == cand_q[DIG_W*j +: DIG_W]) cand_ok = 1'b0;
                if (cand_q[DIG_W*i +: DIG_W] == sel_guess[DIG_W*j +: DIG_W]) begin
                    if (i == j) cand_bulls = cand_bulls + 4'd1;
                    else        cand_cows  = cand_cows + 4'd1;
                end
            end
        end
        cand_match = (cand_bulls == sel_bulls) && (cand_cows == sel_cows);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        guess_d      = guess_q;
        idx_d        = idx_q;
        hist_count_d = hist_count_q;
        hist_guess_d = hist_guess_q;
        hist_bulls_d = hist_bulls_q;
        hist_cows_d  = hist_cows_q;
        inc_req      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    hist_count_d = '0;
                    cand_d       = FIRST_CODE;
                    idx_d        = '0;
                    state_d      = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (!cand_ok) begin
                    inc_req = 1'b1;
                end else if (idx_q == hist_count_q) begin
                    guess_d = cand_q;
                    state_d = S_ISSUE;
                end else if (cand_match) begin
                    idx_d = idx_q + 4'd1;
                end else begin
                    inc_req = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (score_valid) begin
                    for (int unsigned i = 0; i < MAX_GUESSES; i++) begin
                        if (CNT_W'(i) == hist_count_q) begin
                            hist_guess_d[i] = guess_q;
                            hist_bulls_d[i] = bulls;
                            hist_cows_d[i]  = cows;
                        end
                    end
                    hist_count_d = hist_count_q + 4'd1;
                    if (bulls == 4'd4) begin
                        state_d = S_DONE;
                    end else if (hist_count_d == CNT_W'(MAX_GUESSES)) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_SEARCH;
                        inc_req = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Stepping past the highest legal code means the history is unsatisfiable
        if (inc_req) begin
            if (cand_q >= LAST_CODE) begin
                state_d = S_FAIL;
            end else begin
                cand_d = bcd_inc(cand_q);
                idx_d  = '0;
            end
        end

        confirm_d = (state_d == S_ISSUE);
        busy_d    = (state_d == S_SEARCH) || (state_d == S_ISSUE) || (state_d == S_WAIT);
        solved_d  = (state_d == S_DONE);
        fail_d    = (state_d == S_FAIL);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cand_q       <= FIRST_CODE;
            guess_q      <= '0;
            idx_q        <= '0;
            hist_count_q <= '0;
            confirm_q    <= 1'b0;
            busy_q       <= 1'b0;
            solved_q     <= 1'b0;
            fail_q       <= 1'b0;
            for (int unsigned i = 0; i < MAX_GUESSES; i++) begin
                hist_guess_q[i] <= '0;
                hist_bulls_q[i] <= '0;
                hist_cows_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            guess_q      <= guess_d;
            idx_q        <= idx_d;
            hist_count_q <= hist_count_d;
            confirm_q    <= confirm_d;
            busy_q       <= busy_d;
            solved_q     <= solved_d;
            fail_q       <= fail_d;
            hist_guess_q <= hist_guess_d;
            hist_bulls_q <= hist_bulls_d;
            hist_cows_q  <= hist_cows_d;
        end
    end

    assign guess       = guess_q;
    assign confirm     = confirm_q;
    assign busy        = busy_q;
    assign solved      = solved_q;
    assign fail        = fail_q;
    assign guess_count = hist_count_q;

endmodule

// File: tb/tb_bulls_cows_solver.sv
// Scoreboard bench for bulls_cows_solver: a decimal-arithmetic model predicts each
// guess, a monitor pops predictions on every confirm pulse.
module tb_bulls_cows_solver;

    localparam int MAXG = 10;

    logic        clock = 1'b0;
    logic        reset, start, score_valid;
    logic [3:0]  bulls, cows;
    logic [15:0] guess;
    logic        confirm, busy, solved, fail;
    logic [3:0]  guess_count;

    logic        start1, score_valid1;
    logic [3:0]  bulls1, cows1;
    logic [15:0] guess1;
    logic        confirm1, busy1, solved1, fail1;
    logic [3:0]  guess_count1;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] exp_q [$];
    logic [15:0] mon_exp;
    logic        prev_confirm = 1'b0;

    int h_code [16];
    int h_b    [16];
    int h_c    [16];
    int h_n;

    always #5 clock = ~clock;

    bulls_cows_solver #(.MAX_GUESSES(MAXG)) dut (
        .clock(clock), .reset(reset), .start(start), .score_valid(score_valid),
        .bulls(bulls), .cows(cows), .guess(guess), .confirm(confirm), .busy(busy),
        .solved(solved), .fail(fail), .guess_count(guess_count)
    );

    bulls_cows_solver #(.MAX_GUESSES(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .score_valid(score_valid1),
        .bulls(bulls1), .cows(cows1), .guess(guess1), .confirm(confirm1), .busy(busy1),
        .solved(solved1), .fail(fail1), .guess_count(guess_count1)
    );

    // ---------------- reference model (decimal arithmetic) ----------------
    function automatic int digit(int v, int i);
        int x;
        x = v;
        for (int k = 0; k < i; k++) x = x / 10;
        return x % 10;
    endfunction

    function automatic int dmask(int v);
        int m;
        m = 0;
        for (int i = 0; i < 4; i++) m = m | (1 << digit(v, i));
        return m;
    endfunction

    function automatic bit valid_code(int v);
        return $countones(dmask(v)) == 4;
    endfunction

    function automatic int bulls_of(int a, int b);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) if (digit(a, i) == digit(b, i)) n++;
        return n;
    endfunction

    function automatic int cows_of(int a, int b);
        return $countones(dmask(a) & dmask(b)) - bulls_of(a, b);
    endfunction

    function automatic int next_guess(int from);
        bit ok;
        for (int v = from; v <= 9999; v++) begin
            if (valid_code(v)) begin
                ok = 1'b1;
                for (int k = 0; k < h_n; k++)
                    if (bulls_of(v, h_code[k]) != h_b[k] || cows_of(v, h_code[k]) != h_c[k]) ok = 1'b0;
                if (ok) return v;
            end
        end
        return -1;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        return {4'(digit(v, 3)), 4'(digit(v, 2)), 4'(digit(v, 1)), 4'(digit(v, 0))};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (confirm) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_confirm: guess=%h, no guess outstanding", guess);
            end else begin
                mon_exp = exp_q.pop_front();
                if (guess !== mon_exp) begin
                    miscompares++;
                    $display("FAIL guess: got %h expected %h", guess, mon_exp);
                end
            end
            if (prev_confirm) begin
                miscompares++;
                $display("FAIL confirm_back_to_back: got 1 expected 0");
            end
        end
        prev_confirm = confirm;
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(string name, int actual, int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_confirm(output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < 40000) begin
            if (confirm) begin
                ok = 1'b1;
                break;
            end
            if (!busy) break;
            @(negedge clock);
            cycles++;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL confirm_wait: got none after %0d cycles expected a confirm", cycles);
            exp_q.delete();
        end
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("idle_wait", int'(busy), 0);
    endtask

    task automatic drive_score(int b, int c);
        score_valid = 1'b1;
        bulls = 4'(b);
        cows  = 4'(c);
        @(negedge clock);
        score_valid = 1'b0;
    endtask

    task automatic send_score(int b, int c);
        @(negedge clock);
        drive_score(b, c);
    endtask

    task automatic check_outputs_reset(string tag);
        check({tag, "_guess"}, int'(guess), 0);
        check({tag, "_confirm"}, int'(confirm), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_solved"}, int'(solved), 0);
        check({tag, "_fail"}, int'(fail), 0);
        check({tag, "_count"}, int'(guess_count), 0);
    endtask

    task automatic play_secret(int secret);
        int g, b, c, cyc;
        bit ok;
        h_n = 0;
        g = next_guess(0);
        pulse_start();
        forever begin
            if (g < 0) begin
                wait_idle(40000);
                check("rand_fail", int'(fail), 1);
                check("rand_fail_count", int'(guess_count), h_n);
                return;
            end
            exp_q.push_back(to_bcd(g));
            wait_confirm(cyc, ok);
            if (!ok) return;
            b = bulls_of(g, secret);
            c = cows_of(g, secret);
            send_score(b, c);
            h_code[h_n] = g;
            h_b[h_n] = b;
            h_c[h_n] = c;
            h_n++;
            if (b == 4) begin
                check("rand_solved", int'(solved), 1);
                check("rand_count", int'(guess_count), h_n);
                return;
            end
            if (h_n == MAXG) begin
                check("rand_budget_fail", int'(fail), 1);
                return;
            end
            g = next_guess(g + 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, secret, n;
        bit ok;
        reset = 1'b1; start = 1'b0; score_valid = 1'b0; bulls = '0; cows = '0;
        start1 = 1'b0; score_valid1 = 1'b0; bulls1 = '0; cows1 = '0;
        repeat (2) @(negedge clock);
        check_outputs_reset("reset");
        reset = 1'b0;
        @(negedge clock);
        drive_score(4, 0);
        check("idle_score_count", int'(guess_count), 0);
        check("idle_score_solved", int'(solved), 0);

        // first guess and immediate win
        exp_q.push_back(16'h0123);
        pulse_start();
        check("search_confirm", int'(confirm), 0);
        check("search_busy", int'(busy), 1);
        wait_confirm(cyc, ok);
        check("first_latency", cyc, 1);
        check("issue_busy", int'(busy), 1);
        send_score(4, 0);
        check("win_solved", int'(solved), 1);
        check("win_busy", int'(busy), 0);
        check("win_count", int'(guess_count), 1);
        repeat (5) @(negedge clock);

        // two-step solve of 4567, with a strobe coincident with confirm
        exp_q.push_back(16'h0123);
        pulse_start();
        wait_confirm(cyc, ok);
        drive_score(4, 0);
        check("coincident_count", int'(guess_count), 0);
        check("coincident_solved", int'(solved), 0);
        check("coincident_busy", int'(busy), 1);
        drive_score(0, 0);
        exp_q.push_back(16'h4567);
        wait_confirm(cyc, ok);
        send_score(4, 0);
        check("two_step_solved", int'(solved), 1);
        check("two_step_count", int'(guess_count), 2);

        // inconsistent feedback leaves only digits 8 and 9
        exp_q.push_back(16'h0123);
        pulse_start();
        wait_confirm(cyc, ok);
        send_score(0, 0);
        exp_q.push_back(16'h4567);
        wait_confirm(cyc, ok);
        send_score(0, 0);
        wait_idle(20000);
        check("inconsistent_fail", int'(fail), 1);
        check("inconsistent_count", int'(guess_count), 2);
        check("inconsistent_solved", int'(solved), 0);
        exp_q.push_back(16'h0123);
        pulse_start();
        check("restart_count", int'(guess_count), 0);
        check("restart_fail", int'(fail), 0);
        wait_confirm(cyc, ok);

        // reset while waiting for a score
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_outputs_reset("abort");
        reset = 1'b0;
        @(negedge clock);
        drive_score(4, 0);
        check("abort_score_count", int'(guess_count), 0);
        check("abort_score_solved", int'(solved), 0);
        repeat (5) @(negedge clock);

        // single-guess budget instance
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        n = 0;
        while (!confirm1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("budget_confirm", int'(confirm1), 1);
        check("budget_guess", int'(guess1), 16'h0123);
        @(negedge clock);
        score_valid1 = 1'b1; bulls1 = 4'd1; cows1 = 4'd1;
        @(negedge clock);
        score_valid1 = 1'b0;
        check("budget_fail", int'(fail1), 1);
        check("budget_count", int'(guess_count1), 1);
        check("budget_busy", int'(busy1), 0);
        check("budget_solved", int'(solved1), 0);

        // randomized self-play against secrets below 3000
        repeat (6) begin
            do secret = int'($urandom_range(2999, 0)); while (!valid_code(secret));
            play_secret(secret);
            repeat (2) @(negedge clock);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
